// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// It issues load-use bubbles, control-hazard flushes and data-memory freezes, and keeps hazard statistics.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_Rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        dmem_wait,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic        fault,
    output logic [15:0] lu_stalls,
    output logic [15:0] flushes
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_FAULT    = 2'd2;
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    logic [1:0]  r_state;
    logic [7:0]  r_wcnt;
    logic        r_fault;
    logic [15:0] r_lu_stalls;
    logic [15:0] r_flushes;

    logic w_lu;
    logic w_ch;
    logic w_freeze;
    logic w_lu_issue;
    logic w_flush_issue;

    // A load to $0 never creates a dependency, so it is excluded outright.
    assign w_lu = idex_mem_read && (idex_Rt != 5'd0) &&
                  ((id_uses_rs && (id_rs == idex_Rt)) ||
                   (id_uses_rt && (id_rt == idex_Rt)));
    assign w_ch     = branch_taken | jump;
    assign w_freeze = dmem_wait | (r_state == S_FAULT);

    assign w_lu_issue    = !rst && !w_freeze && w_lu;
    assign w_flush_issue = !rst && !w_freeze && !w_lu && w_ch;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (rst) begin
            // Push NOPs downstream while reset is held.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (w_lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (w_ch) begin
            ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_wcnt  <= 8'd0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (dmem_wait) begin
                        r_state <= S_MEM_WAIT;
                        r_wcnt  <= 8'd1;
                    end
                end
                S_MEM_WAIT: begin
                    if (!dmem_wait) begin
                        r_state <= S_RUN;
                        r_wcnt  <= 8'd0;
                    end else if (r_wcnt == TIMEOUT_CNT) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_RUN;
                    r_wcnt  <= 8'd0;
                end
            endcase
        end
    end

    // Statistics saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_stalls <= 16'd0;
            r_flushes   <= 16'd0;
        end else begin
            if (w_lu_issue && (r_lu_stalls != 16'hFFFF)) begin
                r_lu_stalls <= r_lu_stalls + 16'd1;
            end
            if (w_flush_issue && (r_flushes != 16'hFFFF)) begin
                r_flushes <= r_flushes + 16'd1;
            end
        end
    end

    assign fault     = r_fault;
    assign lu_stalls = r_lu_stalls;
    assign flushes   = r_flushes;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4.
// Expected values are hand-derived; outputs are checked 1 time unit after inputs change or after a posedge.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        idex_mem_read;
    logic [4:0]  idex_Rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        branch_taken;
    logic        jump;
    logic        dmem_wait;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_freeze;
    logic        fault;
    logic [15:0] lu_stalls;
    logic [15:0] flushes;

    int n_vec;
    int n_err;

    hazard_ctrl #(.MEM_TIMEOUT(4)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .idex_mem_read (idex_mem_read),
        .idex_Rt       (idex_Rt),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .dmem_wait     (dmem_wait),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .pipe_freeze   (pipe_freeze),
        .fault         (fault),
        .lu_stalls     (lu_stalls),
        .flushes       (flushes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
    localparam logic [4:0] O_RST    = 5'b00110;
    localparam logic [4:0] O_NORM   = 5'b11000;
    localparam logic [4:0] O_BUBBLE = 5'b00010;
    localparam logic [4:0] O_FLUSH  = 5'b11100;
    localparam logic [4:0] O_FREEZE = 5'b00001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [4:0] exp);
        #1;
        chk(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}, {27'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        idex_mem_read = 1'b0;
        idex_Rt       = 5'd0;
        id_rs         = 5'd0;
        id_rt         = 5'd0;
        id_uses_rs    = 1'b0;
        id_uses_rt    = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        dmem_wait     = 1'b0;
    endtask

    task automatic set_lu_rs8();
        idex_mem_read = 1'b1;
        idex_Rt       = 5'd8;
        id_rs         = 5'd8;
        id_uses_rs    = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        rst = 1'b1;

        // Reset behaviour
        chk_outs("rst_outs_pre", O_RST);
        tick();
        tick();
        chk_outs("rst_outs", O_RST);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_lu", {16'd0, lu_stalls}, 32'd0);
        chk("rst_fl", {16'd0, flushes}, 32'd0);
        rst = 1'b0;
        chk_outs("idle_outs", O_NORM);

        // Load-use on rs: one bubble, then the bubble clears idex_mem_read
        set_lu_rs8();
        chk_outs("lu_rs_outs", O_BUBBLE);
        tick();
        chk("lu_rs_cnt", {16'd0, lu_stalls}, 32'd1);
        idex_mem_read = 1'b0;
        chk_outs("lu_after_outs", O_NORM);
        tick();
        chk("lu_after_cnt", {16'd0, lu_stalls}, 32'd1);

        // Load-use on rt
        clear_inputs();
        idex_mem_read = 1'b1;
        idex_Rt       = 5'd5;
        id_rt         = 5'd5;
        id_uses_rt    = 1'b1;
        chk_outs("lu_rt_outs", O_BUBBLE);
        tick();
        chk("lu_rt_cnt", {16'd0, lu_stalls}, 32'd2);

        // Load to $0 never stalls
        clear_inputs();
        idex_mem_read = 1'b1;
        id_uses_rs    = 1'b1;
        chk_outs("lu_r0_outs", O_NORM);
        tick();
        chk("lu_r0_cnt", {16'd0, lu_stalls}, 32'd2);

        // Matching but unused source does not stall
        clear_inputs();
        idex_mem_read = 1'b1;
        idex_Rt       = 5'd9;
        id_rt         = 5'd9;
        id_rs         = 5'd3;
        id_uses_rs    = 1'b1;
        chk_outs("lu_unused_outs", O_NORM);
        tick();
        chk("lu_unused_cnt", {16'd0, lu_stalls}, 32'd2);

        // Branch and jump flushes
        clear_inputs();
        branch_taken = 1'b1;
        chk_outs("br_outs", O_FLUSH);
        tick();
        chk("br_cnt", {16'd0, flushes}, 32'd1);
        branch_taken = 1'b0;
        jump = 1'b1;
        chk_outs("jmp_outs", O_FLUSH);
        tick();
        chk("jmp_cnt", {16'd0, flushes}, 32'd2);

        // Branch with load-use: bubble wins, branch is taken the next cycle
        clear_inputs();
        branch_taken = 1'b1;
        set_lu_rs8();
        chk_outs("br_lu_outs", O_BUBBLE);
        tick();
        chk("br_lu_fl", {16'd0, flushes}, 32'd2);
        chk("br_lu_lu", {16'd0, lu_stalls}, 32'd3);
        idex_mem_read = 1'b0;
        chk_outs("br_after_outs", O_FLUSH);
        tick();
        chk("br_after_fl", {16'd0, flushes}, 32'd3);

        // Memory wait of 3 cycles with a pending load-use: freeze only
        clear_inputs();
        dmem_wait = 1'b1;
        set_lu_rs8();
        for (int i = 0; i < 3; i++) begin
            chk_outs("mw_outs", O_FREEZE);
            tick();
            chk("mw_lu", {16'd0, lu_stalls}, 32'd3);
            chk("mw_fl", {16'd0, flushes}, 32'd3);
        end
        dmem_wait = 1'b0;
        chk_outs("mw_release_outs", O_BUBBLE);
        chk("mw_fault", {31'd0, fault}, 32'd0);
        tick();
        chk("mw_release_lu", {16'd0, lu_stalls}, 32'd4);
        clear_inputs();
        chk_outs("mw_norm_outs", O_NORM);

        // Exactly MEM_TIMEOUT wait cycles: no fault
        dmem_wait = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        dmem_wait = 1'b0;
        chk_outs("mw4_outs", O_NORM);
        tick();
        chk("mw4_fault", {31'd0, fault}, 32'd0);

        // MEM_TIMEOUT+1 wait cycles: fault
        dmem_wait = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("to_fault_pre", {31'd0, fault}, 32'd0);
        tick();
        chk("to_fault", {31'd0, fault}, 32'd1);
        dmem_wait = 1'b0;
        branch_taken = 1'b1;
        chk_outs("to_freeze_outs", O_FREEZE);
        tick();
        chk("to_fl", {16'd0, flushes}, 32'd3);
        chk("to_fault_hold", {31'd0, fault}, 32'd1);
        chk_outs("to_freeze_hold", O_FREEZE);

        // Reset clears fault, counters and freeze
        rst = 1'b1;
        chk_outs("to_rst_outs", O_RST);
        tick();
        rst = 1'b0;
        clear_inputs();
        chk("post_rst_fault", {31'd0, fault}, 32'd0);
        chk("post_rst_lu", {16'd0, lu_stalls}, 32'd0);
        chk("post_rst_fl", {16'd0, flushes}, 32'd0);
        chk_outs("post_rst_outs", O_NORM);

        // Saturation: every cycle is a control hazard, alternating branch and jump
        for (int i = 0; i < 70000; i++) begin
            branch_taken = ~i[0];
            jump         = i[0];
            tick();
            if (i == 65533) chk("sat_pre", {16'd0, flushes}, 32'h0000FFFE);
            if (i == 65534) chk("sat_hit", {16'd0, flushes}, 32'h0000FFFF);
        end
        chk("sat_end", {16'd0, flushes}, 32'h0000FFFF);
        chk("sat_lu", {16'd0, lu_stalls}, 32'd0);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
